// File: rtl/mult_div_ctrl.sv
// Sequencer for a shift-add multiplier / non-restoring divider datapath.
// Latency: data_ready N_CYCLES+2 cycles after a multiply start, N_CYCLES+3 after a divide, 2 after divide-by-zero.
// Backpressure: none; a start seen in any state aborts the current operation and restarts from LOAD.
module mult_div_ctrl #(
  parameter int N_CYCLES = 32,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             divisor_zero,
  input  logic             q_msb,
  input  logic             rem_neg,
  output logic             acc_en,
  output logic             acc_sl1,
  output logic             acc_clr,
  output logic             q_en,
  output logic             q_sl1,
  output logic             q_load,
  output logic             add_en,
  output logic             b_invert,
  output logic             q_lsb_in,
  output logic             busy,
  output logic             data_ready,
  output logic             data_exception,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CYCLES - 1);

  state_t           state, state_nxt;
  logic             op_div, op_div_nxt;
  logic             dz_lat, dz_lat_nxt;
  logic             neg_flag, neg_flag_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             start;

  assign start = ctrl_mult | ctrl_div;

  // Next-state and next-value logic; a start overrides whatever is in progress.
  always_comb begin
    state_nxt    = state;
    op_div_nxt   = op_div;
    dz_lat_nxt   = dz_lat;
    neg_flag_nxt = neg_flag;
    count_nxt    = count;
    if (start) begin
      state_nxt    = LOAD;
      op_div_nxt   = ctrl_div & ~ctrl_mult;
      dz_lat_nxt   = divisor_zero;
      neg_flag_nxt = 1'b0;
      count_nxt    = '0;
    end else begin
      case (state)
        LOAD: begin
          neg_flag_nxt = 1'b0;
          count_nxt    = '0;
          state_nxt    = (op_div && dz_lat) ? DONE : RUN;
        end
        RUN: begin
          count_nxt = count + CNT_W'(1);
          if (op_div) neg_flag_nxt = rem_neg;
          if (count == LAST_CNT) state_nxt = op_div ? FIX : DONE;
        end
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, operation context and Moore outputs, registered from the next state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state          <= IDLE;
      op_div         <= 1'b0;
      dz_lat         <= 1'b0;
      neg_flag       <= 1'b0;
      count          <= '0;
      acc_en         <= 1'b0;
      acc_sl1        <= 1'b0;
      acc_clr        <= 1'b0;
      q_en           <= 1'b0;
      q_sl1          <= 1'b0;
      q_load         <= 1'b0;
      busy           <= 1'b0;
      data_ready     <= 1'b0;
      data_exception <= 1'b0;
    end else begin
      state          <= state_nxt;
      op_div         <= op_div_nxt;
      dz_lat         <= dz_lat_nxt;
      neg_flag       <= neg_flag_nxt;
      count          <= count_nxt;
      acc_en         <= (state_nxt == RUN) || ((state_nxt == FIX) && neg_flag_nxt);
      acc_sl1        <= (state_nxt == RUN);
      acc_clr        <= (state_nxt == LOAD);
      q_en           <= (state_nxt == LOAD) || (state_nxt == RUN);
      q_sl1          <= (state_nxt == RUN);
      q_load         <= (state_nxt == LOAD);
      busy           <= (state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == FIX);
      data_ready     <= (state_nxt == DONE);
      data_exception <= (state_nxt == DONE) && op_div_nxt && dz_lat_nxt;
    end
  end

  // ALU controls: follow the live datapath bits during RUN; FIX restores a negative remainder.
  always_comb begin
    add_en   = 1'b0;
    b_invert = 1'b0;
    q_lsb_in = 1'b0;
    if (state == RUN) begin
      add_en   = op_div ? 1'b1 : q_msb;
      b_invert = op_div & ~neg_flag;
      q_lsb_in = op_div & ~rem_neg;
    end else if (state == FIX) begin
      add_en = neg_flag;
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed table, restart/reset sequences, random traffic vs a cycle-count model.
// Latency: checks data_ready timing relative to the cycle the start is sampled.
// Backpressure: not applicable; starts may be issued in any cycle.
module tb_mult_div_ctrl;

  localparam int N     = 32;
  localparam int CNT_W = 6;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_FIX  = 3;
  localparam int P_DONE = 4;

  logic             clk, clr_n;
  logic             ctrl_mult, ctrl_div, divisor_zero, q_msb, rem_neg;
  logic             acc_en, acc_sl1, acc_clr, q_en, q_sl1, q_load;
  logic             add_en, b_invert, q_lsb_in, busy, data_ready, data_exception;
  logic [CNT_W-1:0] count;

  mult_div_ctrl #(.N_CYCLES(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .divisor_zero(divisor_zero), .q_msb(q_msb), .rem_neg(rem_neg),
    .acc_en(acc_en), .acc_sl1(acc_sl1), .acc_clr(acc_clr), .q_en(q_en),
    .q_sl1(q_sl1), .q_load(q_load), .add_en(add_en), .b_invert(b_invert),
    .q_lsb_in(q_lsb_in), .busy(busy), .data_ready(data_ready),
    .data_exception(data_exception), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: an operation is described by how many cycles have elapsed since its start.
  logic m_active, m_div, m_dz, m_neg;
  int   m_t, m_cnt;

  logic last_dr, last_exc, last_run;

  typedef struct {
    logic m;
    logic d;
    logic dz;
    logic rlast;
    int   lat;
    logic exc;
    int   runs;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_vec();
    return {acc_en, acc_sl1, acc_clr, q_en, q_sl1, q_load, add_en, b_invert,
            q_lsb_in, busy, data_ready, data_exception, count};
  endfunction

  function automatic int model_phase();
    if (!m_active)             return P_IDLE;
    if (m_t == 1)              return P_LOAD;
    if (m_div && m_dz)         return P_DONE;
    if (m_t <= N + 1)          return P_RUN;
    if (m_t == N + 2)          return m_div ? P_FIX : P_DONE;
    return P_DONE;
  endfunction

  // Expected outputs: {acc_en,acc_sl1,acc_clr,q_en,q_sl1,q_load,add_en,b_invert,q_lsb_in,busy,data_ready,data_exception,count}
  function automatic logic [17:0] model_vec(input logic qm, input logic rn);
    logic [11:0]      f;
    logic [CNT_W-1:0] c;
    f = '0;
    c = CNT_W'(m_cnt % (1 << CNT_W));
    case (model_phase())
      P_LOAD: begin f[9] = 1'b1; f[8] = 1'b1; f[6] = 1'b1; f[2] = 1'b1; end
      P_RUN: begin
        f[11] = 1'b1; f[10] = 1'b1; f[8] = 1'b1; f[7] = 1'b1; f[2] = 1'b1;
        f[5]  = m_div ? 1'b1 : qm;
        f[4]  = m_div & ~m_neg;
        f[3]  = m_div & ~rn;
      end
      P_FIX: begin f[2] = 1'b1; f[11] = m_neg; f[5] = m_neg; end
      P_DONE: begin f[1] = 1'b1; f[0] = m_div & m_dz; end
      default: f = '0;
    endcase
    return {f, c};
  endfunction

  task automatic model_update();
    int ph;
    ph = model_phase();
    if (ctrl_mult || ctrl_div) begin
      m_active = 1'b1; m_t = 1; m_div = ctrl_div & ~ctrl_mult;
      m_dz = divisor_zero; m_cnt = 0; m_neg = 1'b0;
    end else if (m_active) begin
      if (ph == P_RUN) begin
        m_cnt++;
        if (m_div) m_neg = rem_neg;
      end
      if (ph == P_DONE) m_active = 1'b0;
      else m_t++;
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_div = 1'b0; m_dz = 1'b0; m_neg = 1'b0; m_t = 0; m_cnt = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge, then return 1 time unit later.
  task automatic step();
    @(negedge clk);
    check("outputs", 32'(dut_vec()), 32'(model_vec(q_msb, rem_neg)));
    last_dr  = data_ready;
    last_exc = data_exception;
    last_run = q_sl1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Start an operation in this cycle and follow it until data_ready or the cycle budget runs out.
  task automatic run_op(input logic m, input logic d, input logic dz, input logic rlast,
                        output int lat, output logic exc, output int runs);
    ctrl_mult = m; ctrl_div = d; divisor_zero = dz; q_msb = 1'b1; rem_neg = 1'b0;
    step();
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    lat = -1; exc = 1'b0; runs = 0;
    for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
      divisor_zero = (cyc == 1) ? dz : 1'b0;
      q_msb        = (cyc % 2 == 0);
      rem_neg      = (cyc == N + 1) ? rlast : 1'($urandom % 2);
      step();
      runs += int'(last_run);
      if (last_dr) begin
        lat = cyc;
        exc = last_exc;
      end
    end
  endtask

  initial begin
    int   lat, runs;
    logic exc;

    tbl[0] = '{m:1'b1, d:1'b0, dz:1'b0, rlast:1'b0, lat:N+2, exc:1'b0, runs:N};
    tbl[1] = '{m:1'b0, d:1'b1, dz:1'b0, rlast:1'b1, lat:N+3, exc:1'b0, runs:N};
    tbl[2] = '{m:1'b0, d:1'b1, dz:1'b1, rlast:1'b0, lat:2,   exc:1'b1, runs:0};
    tbl[3] = '{m:1'b1, d:1'b1, dz:1'b1, rlast:1'b1, lat:N+2, exc:1'b0, runs:N};
    tbl[4] = '{m:1'b1, d:1'b0, dz:1'b1, rlast:1'b0, lat:N+2, exc:1'b0, runs:N};
    tbl[5] = '{m:1'b0, d:1'b1, dz:1'b0, rlast:1'b0, lat:N+3, exc:1'b0, runs:N};

    clr_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0;
    divisor_zero = 1'b0; q_msb = 1'b0; rem_neg = 1'b0;
    model_reset();
    #12;
    check("reset_state", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].m, tbl[i].d, tbl[i].dz, tbl[i].rlast, lat, exc, runs);
      check($sformatf("latency[%0d]", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("exception[%0d]", i), 32'(exc), 32'(tbl[i].exc));
      check($sformatf("run_cycles[%0d]", i), 32'(runs), 32'(tbl[i].runs));
      step();
    end

    // Divide start issued while the multiply is on iteration 10.
    ctrl_mult = 1'b1; q_msb = 1'b1;
    step();
    ctrl_mult = 1'b0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      q_msb = 1'($urandom % 2);
      step();
    end
    check("restart_count", 32'(count), 32'd10);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, lat, exc, runs);
    check("restart_latency", 32'(lat), 32'(N + 3));
    step();

    // Reset pulled mid-multiply at iteration 20.
    ctrl_mult = 1'b1;
    step();
    ctrl_mult = 1'b0;
    for (int cyc = 1; cyc <= 21; cyc++) step();
    check("pre_reset_count", 32'(count), 32'd20);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(dut_vec()), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("held_reset_outputs", 32'(dut_vec()), 32'd0);
    clr_n = 1'b1;
    run_op(1'b1, 1'b0, 1'b0, 1'b0, lat, exc, runs);
    check("post_reset_latency", 32'(lat), 32'(N + 2));
    step();

    // Random traffic, including starts landing in every state.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 50 == 0) begin
        ctrl_mult = 1'($urandom % 2);
        ctrl_div  = 1'($urandom % 2);
      end else begin
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
      end
      divisor_zero = ($urandom % 4 == 0);
      q_msb        = 1'($urandom % 2);
      rem_neg      = 1'($urandom % 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have parameter N_CYCLES, default 32, meaning the number of RUN iterations (operand width).
REQ-002 SHALL have parameter CNT_W, default 6, meaning the iteration counter width; CNT_W SHALL satisfy 2^CNT_W > N_CYCLES.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ctrl_mult  input  1  start-multiply pulse.
REQ-006 SHALL have port ctrl_div  input  1  start-divide pulse.
REQ-007 SHALL have port divisor_zero  input  1  divisor operand equals 0, valid in the cycle the start is sampled.
REQ-008 SHALL have port q_msb  input  1  current MSB of the multiplier register.
REQ-009 SHALL have port rem_neg  input  1  sign of the current-cycle ALU result (partial remainder).
REQ-010 SHALL have port acc_en, acc_sl1, acc_clr  output  1 each  accumulator register load enable, shift-left-1 select, clear.
REQ-011 SHALL have port q_en, q_sl1  output  1 each  quotient/multiplier register load enable and shift-left-1 select.
REQ-012 SHALL have port q_load  output  1  select operand input (not shifted feedback) into the quotient/multiplier register.
REQ-013 SHALL have port add_en, b_invert  output  1 each  ALU adds B-operand; b_invert selects inverted B with carry-in 1 (subtract).
REQ-014 SHALL have port q_lsb_in  output  1  bit shifted into the quotient/multiplier LSB.
REQ-015 SHALL have port busy, data_ready, data_exception  output  1 each  operation status.
REQ-016 SHALL have port count  output  CNT_W  current iteration index.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, FIX, DONE in a registered state machine.
REQ-018 SHALL, in any state, sample ctrl_mult/ctrl_div at the clock edge and go to LOAD, latching op_div = ctrl_div & ~ctrl_mult (mult wins when both are high), aborting any operation in progress.
REQ-019 SHALL, in LOAD (exactly 1 cycle), drive acc_clr=1, q_en=1, q_load=1, clear count to 0, clear the neg_flag register, and latch divisor_zero.
REQ-020 SHALL leave LOAD for DONE if op_div and the latched divisor_zero are both 1, and for RUN otherwise.
REQ-021 SHALL, in each RUN cycle, drive acc_en=1, acc_sl1=1, q_en=1, q_sl1=1, and increment count modulo 2^CNT_W.
REQ-022 SHALL, in a multiply RUN cycle, drive add_en=q_msb, b_invert=0, q_lsb_in=0.
REQ-023 SHALL, in a divide RUN cycle (non-restoring), drive add_en=1, b_invert=~neg_flag, q_lsb_in=~rem_neg, and load rem_neg into neg_flag at the edge.
REQ-024 SHALL leave RUN when count==N_CYCLES-1 (the last iteration), going to FIX if op_div and to DONE otherwise.
REQ-025 SHALL, in FIX (1 cycle, divide only), drive acc_en=1, acc_sl1=0, add_en=1, b_invert=0 when neg_flag=1 (remainder restore), and drive no enables when neg_flag=0; then go to DONE.
REQ-026 SHALL, in DONE, assert data_ready=1 for exactly one cycle, assert data_exception=1 in that same cycle only for a divide-by-zero, and then go to IDLE.
REQ-027 SHALL drive busy=1 in LOAD, RUN and FIX, and busy=0 in IDLE and DONE.
REQ-028 SHALL drive every control output not named for the current state to 0; outputs SHALL be Moore-type except add_en, b_invert and q_lsb_in in RUN.
REQ-029 SHALL produce data_ready at these latencies, with the start sampled in cycle 0: multiply in cycle N_CYCLES+2 (34 by default); divide in N_CYCLES+3 (35); divide-by-zero in cycle 2.
REQ-030 SHALL, on a start sampled in DONE, suppress nothing: data_ready is still asserted in that DONE cycle and the next state is LOAD.

Reset
REQ-031 SHALL, while clr_n=0 and independent of clk, force state=IDLE, count=0, neg_flag=0, op_div=0, latched divisor_zero=0, and all outputs to 0.
REQ-032 SHALL, when reset is asserted mid-operation, discard that operation with no data_ready pulse, and SHALL accept a new start on the first clock edge after clr_n rises.

Verification
REQ-033 SHALL cover: ctrl_mult pulse, q_msb pattern 1010... -> LOAD then 32 RUN cycles, add_en follows q_msb, count 0..31, data_ready=1 only in cycle 34, busy=1 in cycles 1-33.
REQ-034 SHALL cover: ctrl_div, rem_neg=1 on the final RUN cycle -> FIX drives acc_en=1, add_en=1, b_invert=0, acc_sl1=0; data_ready in cycle 35, data_exception=0.
REQ-035 SHALL cover: ctrl_div with divisor_zero=1 -> LOAD, then DONE in cycle 2 with data_ready=1, data_exception=1, and no RUN cycles.
REQ-036 SHALL cover: ctrl_mult and ctrl_div both high -> multiply sequence, no FIX cycle, data_ready in cycle 34.
REQ-037 SHALL cover: ctrl_div restarted at count=10 of a multiply -> LOAD next cycle, count=0, data_ready only at 35 cycles after the restart.
REQ-038 SHALL cover: clr_n low at count=20 -> all outputs 0 immediately, no data_ready; a start after release -> normal 34-cycle multiply.
